// File: rtl/gate_reduce_stream.sv
// Streaming gate reducer: folds a run-time number of WIDTH-bit operands through
// a selectable bitwise gate and returns one registered result per command.
module gate_reduce_stream #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_ARITY = 16,
  parameter int unsigned CNT_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] arity,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err
);

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_BUF  = 3'd6;
  localparam logic [2:0] OP_NOT  = 3'd7;

  localparam logic [CNT_W-1:0] MAX_A = CNT_W'(MAX_ARITY);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_nx;
  logic [2:0]       op_q, op_nx;
  logic [CNT_W-1:0] arity_q, arity_nx;
  logic [CNT_W-1:0] count_q, count_nx;
  logic [WIDTH-1:0] acc_q, acc_nx;
  logic [WIDTH-1:0] out_data_q, out_data_nx;
  logic             out_err_q, out_err_nx;
  logic             illegal_c;
  logic             invert_c;
  logic [WIDTH-1:0] folded_c;

  // Handshake flags depend on state only, so no input-to-ready path exists
  assign start_ready = (state_q == IDLE);
  assign in_ready    = (state_q == ACCUM);
  assign out_valid   = (state_q == DONE);
  assign out_data    = out_data_q;
  assign out_err     = out_err_q;

  assign illegal_c = (arity == '0) || (arity > MAX_A) ||
                     (((op == OP_BUF) || (op == OP_NOT)) && (arity != ONE));

  assign invert_c = (op_q == OP_NAND) || (op_q == OP_NOR) ||
                    (op_q == OP_XNOR) || (op_q == OP_NOT);

  // Base gate for the latched op; the inverting variants share the base fold
  always_comb begin
    folded_c = in_data;
    if (count_q != '0) begin
      case (op_q)
        OP_AND, OP_NAND: folded_c = acc_q & in_data;
        OP_OR,  OP_NOR:  folded_c = acc_q | in_data;
        OP_XOR, OP_XNOR: folded_c = acc_q ^ in_data;
        default:         folded_c = in_data;
      endcase
    end
  end

  always_comb begin
    state_nx    = state_q;
    op_nx       = op_q;
    arity_nx    = arity_q;
    count_nx    = count_q;
    acc_nx      = acc_q;
    out_data_nx = out_data_q;
    out_err_nx  = out_err_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          op_nx    = op;
          arity_nx = arity;
          count_nx = '0;
          if (illegal_c) begin
            state_nx    = DONE;
            out_data_nx = '0;
            out_err_nx  = 1'b1;
          end else begin
            state_nx = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_nx   = folded_c;
          count_nx = count_q + ONE;
          if (count_q == (arity_q - ONE)) begin
            state_nx    = DONE;
            out_data_nx = invert_c ? ~folded_c : folded_c;
            out_err_nx  = 1'b0;
          end
        end
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= '0;
      arity_q    <= '0;
      count_q    <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      out_err_q  <= 1'b0;
    end else begin
      state_q    <= state_nx;
      op_q       <= op_nx;
      arity_q    <= arity_nx;
      count_q    <= count_nx;
      acc_q      <= acc_nx;
      out_data_q <= out_data_nx;
      out_err_q  <= out_err_nx;
    end
  end

endmodule

// File: tb/tb_gate_reduce_stream.sv
// Bench for gate_reduce_stream: directed commands with hand-computed results,
// queued as expectations and consumed by an independent output monitor.
module tb_gate_reduce_stream;

  logic       clk;
  logic       rst_n;
  logic       start_valid;
  logic       start_ready;
  logic [2:0] op;
  logic [4:0] arity;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_err;

  int tests = 0;
  int fails = 0;
  int n_in  = 0;
  logic [8:0] exp_q[$];

  gate_reduce_stream #(.WIDTH(8), .MAX_ARITY(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .op(op), .arity(arity),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Operand handshakes, observed between edges
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) n_in++;
  end

  // Result monitor: pops the oldest expectation on every output handshake
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(out_data), 32'hDEAD);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("result_data", 32'(out_data), 32'(e[7:0]));
        check("result_err", 32'(out_err), 32'(e[8]));
      end
    end
  end

  task automatic do_start(input logic [2:0] o, input logic [4:0] a);
    int n = 0;
    op = o; arity = a; start_valid = 1'b1;
    while (!start_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("start_timeout", 32'(start_ready), 32'd1);
    @(posedge clk); #1;
    start_valid = 1'b0; op = 3'd0; arity = 5'd0;
  endtask

  task automatic send(input logic [7:0] d);
    int n = 0;
    in_valid = 1'b1; in_data = d;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("in_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 8'h00;
  endtask

  task automatic wait_result();
    int n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    check("out_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic drain();
    wait_result();
    @(posedge clk); #1;
  endtask

  logic [7:0] deg_exp [8] = '{8'h3C, 8'h3C, 8'h3C, 8'hC3, 8'hC3, 8'hC3, 8'h3C, 8'hC3};

  initial begin
    int base;
    rst_n = 1'b0; start_valid = 1'b0; op = 3'd0; arity = 5'd0;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    #3;
    check("rst_start_ready", 32'(start_ready), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: xor of three back-to-back beats, result one cycle after last accept
    exp_q.push_back({1'b0, 8'h69});
    do_start(3'd2, 5'd3);
    send(8'h0F); send(8'h33);
    check("t1_no_early_valid", 32'(out_valid), 32'd0);
    send(8'h55);
    check("t1_latency", 32'(out_valid), 32'd1);
    drain();

    // 2: xnor with a two-cycle operand gap
    base = n_in;
    exp_q.push_back({1'b0, 8'hA5});
    do_start(3'd5, 5'd4);
    send(8'hFF); send(8'h00);
    repeat (2) @(posedge clk);
    #0 check("t2_gap_hold", 32'(in_ready), 32'd1);
    send(8'hAA); send(8'h0F);
    drain();
    check("t2_beats", 32'(n_in - base), 32'd4);

    // 3: arity 1 for every gate
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({1'b0, deg_exp[i]});
      do_start(3'(i), 5'd1);
      send(8'h3C);
      drain();
    end

    // 4: illegal commands, operands offered but never taken
    base = n_in;
    in_valid = 1'b1; in_data = 8'h77;
    exp_q.push_back({1'b1, 8'h00});
    do_start(3'd0, 5'd0);
    check("t4a_in_ready", 32'(in_ready), 32'd0);
    check("t4a_valid", 32'(out_valid), 32'd1);
    drain();
    exp_q.push_back({1'b1, 8'h00});
    do_start(3'd1, 5'd17);
    check("t4b_in_ready", 32'(in_ready), 32'd0);
    check("t4b_valid", 32'(out_valid), 32'd1);
    drain();
    exp_q.push_back({1'b1, 8'h00});
    do_start(3'd7, 5'd2);
    check("t4c_in_ready", 32'(in_ready), 32'd0);
    check("t4c_valid", 32'(out_valid), 32'd1);
    drain();
    in_valid = 1'b0;
    check("t4_no_beats", 32'(n_in - base), 32'd0);

    // 5: nor with result backpressure
    out_ready = 1'b0;
    exp_q.push_back({1'b0, 8'hEE});
    do_start(3'd4, 5'd2);
    send(8'h01); send(8'h10);
    wait_result();
    for (int k = 0; k < 5; k++) begin
      check("t5_hold_valid", 32'(out_valid), 32'd1);
      check("t5_hold_data", 32'(out_data), 32'hEE);
      check("t5_start_ready", 32'(start_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("t5_idle", 32'(start_ready), 32'd1);
    check("t5_valid_off", 32'(out_valid), 32'd0);

    // 6: asynchronous abort mid-accumulation, then a fresh command
    do_start(3'd0, 5'd4);
    send(8'hF0); send(8'h3C);
    #2 rst_n = 1'b0;
    #1;
    check("t6_start_ready", 32'(start_ready), 32'd1);
    check("t6_in_ready", 32'(in_ready), 32'd0);
    check("t6_out_valid", 32'(out_valid), 32'd0);
    check("t6_out_data", 32'(out_data), 32'd0);
    check("t6_out_err", 32'(out_err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back({1'b0, 8'h81});
    do_start(3'd1, 5'd2);
    send(8'h80); send(8'h01);
    drain();

    // Max arity: 16 xor beats of one-hot-ish values
    exp_q.push_back({1'b0, 8'h00});
    do_start(3'd2, 5'd16);
    for (int k = 0; k < 16; k++) send(8'(1 << (k % 8)));
    drain();

    repeat (3) @(posedge clk);
    #1 check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
